// File: rtl/upsample_pkg.sv
// Shared types and helpers for the N-D upsampling layer: FSM state encoding,
// mode selectors and the counter-width helper.
package upsample_pkg;

   typedef enum logic [1:0] {
      S_READ   = 2'd0,
      S_EMIT_H = 2'd1,
      S_EMIT_V = 2'd2
   } state_e;

   localparam int MODE_ZERO    = 0;
   localparam int MODE_NEAREST = 1;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/upsample_line_buffer.sv
// One-row pixel store for nearest-neighbour mode: synchronous write port,
// combinational read port. Contents need no reset.
module upsample_line_buffer #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Row storage write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsample_nd_layer.sv
// Streaming 2-D upsampler: integer stride on both axes, zero-insertion or
// nearest-neighbour repeat, registered valid/ready output stage.
module upsample_nd_layer
   import upsample_pkg::*;
#(
   parameter int IN_WIDTH   = 14,
   parameter int IN_HEIGHT  = 14,
   parameter int STRIDE     = 2,
   parameter int CHANNELS   = 1,
   parameter int DATA_WIDTH = 16,
   parameter int MODE       = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           valid_in,
   input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
   output logic                           ready_in,
   input  logic                           ready_out,
   output logic                           valid_out,
   output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
   output logic                           last_out
);

   localparam int PW        = CHANNELS * DATA_WIDTH;
   localparam int OUT_WIDTH = IN_WIDTH * STRIDE;
   localparam int CW        = cnt_width(IN_WIDTH - 1);
   localparam int RW        = cnt_width(IN_HEIGHT - 1);
   localparam int SW        = cnt_width(STRIDE);
   localparam int OW        = cnt_width(OUT_WIDTH - 1);

   localparam logic [CW-1:0] COL_LAST  = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IN_HEIGHT - 1);
   localparam logic [SW-1:0] REP_LAST  = SW'((STRIDE > 1) ? STRIDE - 2 : 0);
   localparam logic [SW-1:0] SUB_LAST  = SW'(STRIDE - 1);
   localparam logic [OW-1:0] OCOL_LAST = OW'(OUT_WIDTH - 1);

   state_e        state_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [SW-1:0] rep_q;
   logic [SW-1:0] vrow_q;
   logic [SW-1:0] sub_q;
   logic [CW-1:0] lbcol_q;
   logic [OW-1:0] ocol_q;
   logic          valid_q;
   logic [PW-1:0] data_q;
   logic          last_q;

   logic          adv_s;
   logic          accept_s;
   logic [PW-1:0] lb_rd_s;

   assign adv_s     = !valid_q || ready_out;
   assign ready_in  = (state_q == S_READ) && adv_s;
   assign accept_s  = ready_in && valid_in;
   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign last_out  = last_q;

   generate
      if (MODE == MODE_NEAREST) begin : g_lb
         upsample_line_buffer #(
            .DEPTH (IN_WIDTH),
            .WIDTH (PW),
            .AW    (CW)
         ) u_line_buffer (
            .clk     (clk),
            .we_i    (accept_s),
            .waddr_i (col_q),
            .wdata_i (data_in),
            .raddr_i (lbcol_q),
            .rdata_o (lb_rd_s)
         );
      end else begin : g_no_lb
         assign lb_rd_s = {PW{1'b0}};
      end
   endgenerate

   // Upsampling FSM with registered output stage; everything holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_READ;
         col_q   <= {CW{1'b0}};
         row_q   <= {RW{1'b0}};
         rep_q   <= {SW{1'b0}};
         vrow_q  <= {SW{1'b0}};
         sub_q   <= {SW{1'b0}};
         lbcol_q <= {CW{1'b0}};
         ocol_q  <= {OW{1'b0}};
         valid_q <= 1'b0;
         data_q  <= {PW{1'b0}};
         last_q  <= 1'b0;
      end else if (adv_s) begin
         case (state_q)
            S_READ: begin
               if (valid_in) begin
                  valid_q <= 1'b1;
                  data_q  <= data_in;
                  last_q  <= (STRIDE == 1) && (col_q == COL_LAST) && (row_q == ROW_LAST);
                  if (STRIDE > 1) begin
                     state_q <= S_EMIT_H;
                     rep_q   <= {SW{1'b0}};
                  end else if (col_q == COL_LAST) begin
                     col_q <= {CW{1'b0}};
                     row_q <= (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end else begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
            S_EMIT_H: begin
               valid_q <= 1'b1;
               // data_q still holds the pixel just accepted, so repeating is a hold
               data_q  <= (MODE == MODE_NEAREST) ? data_q : {PW{1'b0}};
               last_q  <= 1'b0;
               if (rep_q == REP_LAST) begin
                  rep_q <= {SW{1'b0}};
                  if (col_q == COL_LAST) begin
                     col_q   <= {CW{1'b0}};
                     ocol_q  <= {OW{1'b0}};
                     vrow_q  <= {SW{1'b0}};
                     sub_q   <= {SW{1'b0}};
                     lbcol_q <= {CW{1'b0}};
                     state_q <= S_EMIT_V;
                  end else begin
                     col_q   <= col_q + CW'(1);
                     state_q <= S_READ;
                  end
               end else begin
                  rep_q <= rep_q + SW'(1);
               end
            end
            S_EMIT_V: begin
               valid_q <= 1'b1;
               data_q  <= lb_rd_s;
               last_q  <= (ocol_q == OCOL_LAST) && (vrow_q == REP_LAST) && (row_q == ROW_LAST);
               if (ocol_q == OCOL_LAST) begin
                  ocol_q  <= {OW{1'b0}};
                  sub_q   <= {SW{1'b0}};
                  lbcol_q <= {CW{1'b0}};
                  if (vrow_q == REP_LAST) begin
                     vrow_q  <= {SW{1'b0}};
                     row_q   <= (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
                     state_q <= S_READ;
                  end else begin
                     vrow_q <= vrow_q + SW'(1);
                  end
               end else begin
                  ocol_q <= ocol_q + OW'(1);
                  // lbcol_q tracks ocol_q / STRIDE without a divider
                  if (sub_q == SUB_LAST) begin
                     sub_q   <= {SW{1'b0}};
                     lbcol_q <= lbcol_q + CW'(1);
                  end else begin
                     sub_q <= sub_q + SW'(1);
                  end
               end
            end
            default: begin
               state_q <= S_READ;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_upsample_nd_layer.sv
// Directed self-checking bench for upsample_nd_layer across four configurations.
module tb_upsample_nd_layer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int          sel;
   logic        vin;
   logic        rout;
   logic [31:0] din;

   logic [3:0]  vi_s, ro_s, ri_s, vo_s, lo_s;
   logic [15:0] do_a, do_b, do_c;
   logic [31:0] do_d;
   logic [31:0] do_s [4];

   logic        dv, dl, dri;
   logic [31:0] dd;

   int checks = 0;
   int errors = 0;

   logic [31:0] pix [$];
   logic [31:0] got_d [$];
   logic        got_l [$];
   int          got_cyc [$];
   int          stall_bad, n_stalls, first_acc, first_cap;

   int tbl_zero [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
   int tbl_near [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};

   for (genvar k = 0; k < 4; k++) begin : g_ctl
      assign vi_s[k] = vin && (sel == k);
      assign ro_s[k] = (sel == k) ? rout : 1'b1;
   end

   assign do_s[0] = {16'h0000, do_a};
   assign do_s[1] = {16'h0000, do_b};
   assign do_s[2] = {16'h0000, do_c};
   assign do_s[3] = do_d;

   always_comb begin
      dv = 1'b0; dl = 1'b0; dri = 1'b0; dd = 32'h0;
      case (sel)
         0, 1, 2, 3: begin
            dv = vo_s[sel]; dl = lo_s[sel]; dri = ri_s[sel]; dd = do_s[sel];
         end
         default: ;
      endcase
   end

   upsample_nd_layer #(.IN_WIDTH(2), .IN_HEIGHT(2), .STRIDE(2), .CHANNELS(1), .DATA_WIDTH(16), .MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .valid_in(vi_s[0]), .data_in(din[15:0]), .ready_in(ri_s[0]),
      .ready_out(ro_s[0]), .valid_out(vo_s[0]), .data_out(do_a), .last_out(lo_s[0]));
   upsample_nd_layer #(.IN_WIDTH(2), .IN_HEIGHT(2), .STRIDE(2), .CHANNELS(1), .DATA_WIDTH(16), .MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .valid_in(vi_s[1]), .data_in(din[15:0]), .ready_in(ri_s[1]),
      .ready_out(ro_s[1]), .valid_out(vo_s[1]), .data_out(do_b), .last_out(lo_s[1]));
   upsample_nd_layer #(.IN_WIDTH(3), .IN_HEIGHT(3), .STRIDE(3), .CHANNELS(1), .DATA_WIDTH(16), .MODE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .valid_in(vi_s[2]), .data_in(din[15:0]), .ready_in(ri_s[2]),
      .ready_out(ro_s[2]), .valid_out(vo_s[2]), .data_out(do_c), .last_out(lo_s[2]));
   upsample_nd_layer #(.IN_WIDTH(2), .IN_HEIGHT(2), .STRIDE(1), .CHANNELS(2), .DATA_WIDTH(16), .MODE(0)) u_d (
      .clk(clk), .rst_n(rst_n), .valid_in(vi_s[3]), .data_in(din), .ready_in(ri_s[3]),
      .ready_out(ro_s[3]), .valid_out(vo_s[3]), .data_out(do_d), .last_out(lo_s[3]));

   // Drives pix[] into the selected DUT and collects every word taken downstream.
   task automatic run_stream(input int n_in, input int n_out, input int stall_pct, input int budget);
      int idx = 0;
      int cyc = 0;
      logic [31:0] prev_d = 32'h0;
      logic prev_l = 1'b0;
      bit prev_stall = 1'b0;
      got_d.delete(); got_l.delete(); got_cyc.delete();
      stall_bad = 0; n_stalls = 0; first_acc = -1; first_cap = -1;
      while (got_d.size() < n_out && cyc < budget) begin
         @(negedge clk);
         rout = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
         vin  = (idx < n_in);
         din  = (idx < n_in) ? pix[idx] : 32'h0;
         #1;
         if (prev_stall && (!dv || dd !== prev_d || dl !== prev_l)) stall_bad++;
         if (dv && !rout && dri) stall_bad++;
         if (dv && !rout) n_stalls++;
         if (dv && rout) begin
            got_d.push_back(dd); got_l.push_back(dl); got_cyc.push_back(cyc);
            if (first_cap < 0) first_cap = cyc;
         end
         if (vin && dri) begin
            if (first_acc < 0) first_acc = cyc;
            idx++;
         end
         prev_stall = dv && !rout;
         prev_d = dd;
         prev_l = dl;
         cyc++;
      end
      vin = 1'b0;
      rout = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vin = 1'b0; rout = 1'b1; din = 32'h0; sel = 0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (vo_s[k] !== 1'b0 || lo_s[k] !== 1'b0 || do_s[k] !== 32'h0 || ri_s[k] !== 1'b1) begin
            errors++;
            $display("FAIL reset dut%0d: valid=%b last=%b data=%h ready_in=%b, want 0 0 0 1",
                     k, vo_s[k], lo_s[k], do_s[k], ri_s[k]);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Compares one collected S=2 frame (starting at got index base) against a table.
   task automatic check_s2_frame(input string name, input int base, input int offset, input bit nearest);
      int e;
      logic [31:0] exp_v;
      for (int i = 0; i < 16; i++) begin
         e = nearest ? tbl_near[i] : tbl_zero[i];
         exp_v = (e == 0) ? 32'h0 : 32'(e + offset);
         checks++;
         if (base + i >= got_d.size()) begin
            errors++;
            $display("FAIL %s word %0d: missing, want %h", name, base + i, exp_v);
         end else if (got_d[base+i] !== exp_v || got_l[base+i] !== (i == 15)) begin
            errors++;
            $display("FAIL %s word %0d: got data=%h last=%b, want data=%h last=%b",
                     name, base + i, got_d[base+i], got_l[base+i], exp_v, (i == 15));
         end
      end
   endtask

   task automatic test_zero_s2();
      sel = 0; pix = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_stream(4, 16, 0, 200);
      check_s2_frame("zero_s2", 0, 0, 1'b0);
   endtask

   task automatic test_nearest_s2();
      sel = 1; pix = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_stream(4, 16, 0, 200);
      check_s2_frame("nearest_s2", 0, 0, 1'b1);
   endtask

   task automatic test_stall_s3();
      logic [31:0] exp_v;
      sel = 2; pix.delete();
      for (int i = 1; i <= 9; i++) pix.push_back(32'(i));
      run_stream(9, 81, 50, 3000);
      for (int i = 0; i < 81; i++) begin
         // nonzero only where output row and column are both multiples of 3
         exp_v = ((i / 9) % 3 == 0 && (i % 9) % 3 == 0) ? 32'((i / 27) * 3 + (i % 9) / 3 + 1) : 32'h0;
         checks++;
         if (i >= got_d.size()) begin
            errors++;
            $display("FAIL stall_s3 word %0d: missing, want %h", i, exp_v);
         end else if (got_d[i] !== exp_v || got_l[i] !== (i == 80)) begin
            errors++;
            $display("FAIL stall_s3 word %0d: got data=%h last=%b, want data=%h last=%b",
                     i, got_d[i], got_l[i], exp_v, (i == 80));
         end
      end
      checks++;
      if (stall_bad !== 0 || n_stalls == 0) begin
         errors++;
         $display("FAIL stall_hold: violations=%0d stalls=%0d, want 0 violations and >0 stalls",
                  stall_bad, n_stalls);
      end
   endtask

   task automatic test_passthrough_s1();
      sel = 3; pix = '{32'hFFFF_0001, 32'h8000_0002, 32'h1234_5678, 32'h0000_ABCD};
      run_stream(4, 4, 0, 100);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= got_d.size()) begin
            errors++;
            $display("FAIL s1 word %0d: missing, want %h", i, pix[i]);
         end else if (got_d[i] !== pix[i] || got_l[i] !== (i == 3)) begin
            errors++;
            $display("FAIL s1 word %0d: got data=%h last=%b, want data=%h last=%b",
                     i, got_d[i], got_l[i], pix[i], (i == 3));
         end
      end
      checks++;
      if (first_cap - first_acc !== 1) begin
         errors++;
         $display("FAIL s1_latency: got %0d cycles, want 1", first_cap - first_acc);
      end
   endtask

   task automatic test_reset_mid_frame();
      sel = 1; pix = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_stream(2, 6, 0, 100);
      rst_n = 1'b0;
      #1;
      checks++;
      if (dv !== 1'b0 || dl !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b last=%b, want 0 0", dv, dl);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pix = '{32'd5, 32'd6, 32'd7, 32'd8};
      run_stream(4, 16, 0, 200);
      check_s2_frame("after_reset", 0, 4, 1'b1);
   endtask

   task automatic test_back_to_back();
      int n_last = 0;
      sel = 0; pix.delete();
      for (int i = 1; i <= 8; i++) pix.push_back(32'(i));
      run_stream(8, 32, 0, 300);
      check_s2_frame("b2b_f0", 0, 0, 1'b0);
      check_s2_frame("b2b_f1", 16, 4, 1'b0);
      foreach (got_l[i]) if (got_l[i]) n_last++;
      checks++;
      if (n_last !== 2) begin
         errors++;
         $display("FAIL b2b_last_count: got %0d, want 2", n_last);
      end
      checks++;
      if (got_cyc.size() != 32 || got_cyc[31] - got_cyc[0] !== 31) begin
         errors++;
         $display("FAIL b2b_gapless: got %0d words spanning %0d cycles, want 32 words over 31",
                  got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1);
      end
   endtask

   initial begin
      test_reset();
      test_zero_s2();
      test_nearest_s2();
      test_stall_s3();
      test_passthrough_s1();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
